// File: rtl/riscv_imm_pkg.sv
// Shared RISC-V base-ISA opcode constants, immediate-type codes and XLEN legality
// helper for the immediate-generation stage.
package riscv_imm_pkg;

  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_MISC_MEM  = 7'b0001111;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_U    = 3'd4,
    IMM_J    = 3'd5,
    IMM_Z    = 3'd6
  } imm_type_e;

  function automatic bit xlen_legal(input int xlen);
    return (xlen == 32) || (xlen == 64);
  endfunction

endpackage

// File: rtl/imm_decode_core.sv
// Combinational RV32I/RV64I immediate decoder: instruction word to immediate,
// immediate type and illegal-opcode flag.
module imm_decode_core
  import riscv_imm_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]      instr,
  output logic [XLEN-1:0]  imm,
  output imm_type_e        imm_type,
  output logic             illegal
);

  // Every immediate is assembled as a signed 32-bit value first, then widened.
  function automatic logic [XLEN-1:0] sext32(input logic signed [31:0] v);
    return XLEN'(v);
  endfunction

  logic signed [31:0] imm_i;
  logic signed [31:0] imm_s;
  logic signed [31:0] imm_b;
  logic signed [31:0] imm_u;
  logic signed [31:0] imm_j;

  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {instr[31:12], 12'b0};
  assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  always_comb begin
    imm      = '0;
    imm_type = IMM_NONE;
    illegal  = 1'b0;
    if (instr[1:0] != 2'b11) begin
      illegal = 1'b1;
    end else begin
      case (instr[6:0])
        OPC_LOAD, OPC_OP_IMM, OPC_JALR, OPC_MISC_MEM: begin
          imm_type = IMM_I;
          imm      = sext32(imm_i);
        end
        OPC_STORE: begin
          imm_type = IMM_S;
          imm      = sext32(imm_s);
        end
        OPC_BRANCH: begin
          imm_type = IMM_B;
          imm      = sext32(imm_b);
        end
        OPC_JAL: begin
          imm_type = IMM_J;
          imm      = sext32(imm_j);
        end
        OPC_LUI, OPC_AUIPC: begin
          imm_type = IMM_U;
          imm      = sext32(imm_u);
        end
        OPC_SYSTEM: begin
          // funct3[2] selects the CSR immediate forms, whose zimm lives in rs1.
          if (instr[14]) begin
            imm_type = IMM_Z;
            imm      = XLEN'(instr[19:15]);
          end else begin
            imm_type = IMM_I;
            imm      = sext32(imm_i);
          end
        end
        OPC_OP: begin
          imm_type = IMM_NONE;
        end
        OPC_OP_IMM_32: begin
          if (XLEN == 64) begin
            imm_type = IMM_I;
            imm      = sext32(imm_i);
          end else begin
            illegal = 1'b1;
          end
        end
        OPC_OP_32: begin
          if (XLEN != 64) illegal = 1'b1;
        end
        default: begin
          illegal = 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/imm_decode_stage.sv
// Registered immediate-generation stage between fetch and decode: valid/ready
// handshake, optional two-entry skid buffer and synchronous flush.
module imm_decode_stage
  import riscv_imm_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int SKID = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [XLEN-1:0]  in_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_imm_type,
  output logic             out_illegal,
  output logic [XLEN-1:0]  out_pc,
  output logic [31:0]      out_instr
);

  if (!xlen_legal(XLEN)) begin : g_bad_xlen
    $error("imm_decode_stage: XLEN must be 32 or 64");
  end

  typedef struct packed {
    logic [XLEN-1:0] imm;
    logic [2:0]      ty;
    logic            ill;
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
  } entry_t;

  logic [XLEN-1:0] dec_imm;
  imm_type_e       dec_type;
  logic            dec_ill;
  entry_t          dec_e;

  imm_decode_core #(.XLEN(XLEN)) u_core (
    .instr    (in_instr),
    .imm      (dec_imm),
    .imm_type (dec_type),
    .illegal  (dec_ill)
  );

  assign dec_e = {dec_imm, dec_type, dec_ill, in_pc, in_instr};

  // p0 = skid entry, p1 = output register
  logic   vld_p0;
  logic   vld_p1;
  entry_t ent_p0;
  entry_t ent_p1;
  logic   accept;
  logic   drain;

  assign in_ready = (SKID != 0) ? !vld_p0 : (!vld_p1 || out_ready);
  assign accept   = in_valid && in_ready;
  assign drain    = !vld_p1 || out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
    end else if (flush) begin
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
    end else if (drain) begin
      // The skid entry is older than anything arriving now, so it goes first;
      // in_ready is low while it is held, so no accept can race it.
      if (vld_p0) begin
        vld_p1 <= 1'b1;
        vld_p0 <= 1'b0;
      end else begin
        vld_p1 <= accept;
      end
    end else if (accept && (SKID != 0)) begin
      vld_p0 <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent_p0 <= '0;
      ent_p1 <= '0;
    end else if (drain) begin
      if (vld_p0)      ent_p1 <= ent_p0;
      else if (accept) ent_p1 <= dec_e;
    end else if (accept) begin
      ent_p0 <= dec_e;
    end
  end

  assign out_valid    = vld_p1;
  assign out_imm      = ent_p1.imm;
  assign out_imm_type = ent_p1.ty;
  assign out_illegal  = ent_p1.ill;
  assign out_pc       = ent_p1.pc;
  assign out_instr    = ent_p1.instr;

endmodule

// File: tb/tb_imm_decode_stage.sv
// Scoreboard bench for imm_decode_stage: XLEN=32 and XLEN=64 instances (SKID=1)
// driven in lockstep, expected results queued at accept and compared on output.
module tb_imm_decode_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        out_ready;
  logic [31:0] in_instr;
  logic [63:0] in_pc;

  logic        rdy32, vld32, ill32;
  logic [31:0] imm32, pc32, instr32;
  logic [2:0]  ty32;
  logic        rdy64, vld64, ill64;
  logic [63:0] imm64, pc64;
  logic [31:0] instr64;
  logic [2:0]  ty64;

  imm_decode_stage #(.XLEN(32), .SKID(1)) dut32 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(rdy32), .in_instr(in_instr), .in_pc(in_pc[31:0]),
    .out_valid(vld32), .out_ready(out_ready), .out_imm(imm32), .out_imm_type(ty32),
    .out_illegal(ill32), .out_pc(pc32), .out_instr(instr32)
  );

  imm_decode_stage #(.XLEN(64), .SKID(1)) dut64 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(rdy64), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(vld64), .out_ready(out_ready), .out_imm(imm64), .out_imm_type(ty64),
    .out_illegal(ill64), .out_pc(pc64), .out_instr(instr64)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [31:0] instr;
    logic [63:0] pc;
    logic [63:0] imm32;
    logic [2:0]  ty32;
    logic        ill32;
    logic [63:0] imm64;
    logic [2:0]  ty64;
    logic        ill64;
  } exp_t;

  exp_t q[$];
  exp_t cur;
  exp_t dir[$];

  // Reference decoder: raw field plus its width, sign-extended by shifting.
  function automatic void model(input logic [31:0] i, input bit x64,
                                output logic [63:0] imm, output logic [2:0] ty,
                                output logic ill);
    logic [63:0]        raw;
    logic signed [63:0] t;
    int                 w;
    raw = '0; w = 0; ty = 3'd0; ill = 1'b0; imm = '0;
    if (i[1:0] != 2'b11) ill = 1'b1;
    else begin
      case (i[6:0])
        7'h03, 7'h13, 7'h67, 7'h0F: begin ty = 3'd1; raw = 64'(i[31:20]); w = 12; end
        7'h23: begin ty = 3'd2; raw = 64'({i[31:25], i[11:7]}); w = 12; end
        7'h63: begin ty = 3'd3; raw = 64'({i[31], i[7], i[30:25], i[11:8], 1'b0}); w = 13; end
        7'h6F: begin ty = 3'd5; raw = 64'({i[31], i[19:12], i[20], i[30:21], 1'b0}); w = 21; end
        7'h37, 7'h17: begin ty = 3'd4; raw = 64'({i[31:12], 12'b0}); w = 32; end
        7'h73: begin
          if (i[14]) begin ty = 3'd6; imm = 64'(i[19:15]); end
          else begin ty = 3'd1; raw = 64'(i[31:20]); w = 12; end
        end
        7'h33: ty = 3'd0;
        7'h1B: begin
          if (x64) begin ty = 3'd1; raw = 64'(i[31:20]); w = 12; end
          else ill = 1'b1;
        end
        7'h3B: if (!x64) ill = 1'b1;
        default: ill = 1'b1;
      endcase
    end
    if (w != 0) begin
      t   = raw << (64 - w);
      t   = t >>> (64 - w);
      imm = t;
    end
    if (!x64) imm = {32'b0, imm[31:0]};
  endfunction

  function automatic exp_t mk_model(input logic [31:0] i, input logic [63:0] pc);
    exp_t e;
    e.instr = i;
    e.pc    = pc;
    model(i, 1'b0, e.imm32, e.ty32, e.ill32);
    model(i, 1'b1, e.imm64, e.ty64, e.ill64);
    return e;
  endfunction

  function automatic exp_t mk_lit(input logic [31:0] i, input logic [63:0] pc,
                                  input logic [31:0] m32, input logic [2:0] t32, input logic l32,
                                  input logic [63:0] m64, input logic [2:0] t64, input logic l64);
    exp_t e;
    e.instr = i; e.pc = pc;
    e.imm32 = {32'b0, m32}; e.ty32 = t32; e.ill32 = l32;
    e.imm64 = m64;          e.ty64 = t64; e.ill64 = l64;
    return e;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [6:0]  ops [13];
    logic [31:0] r;
    int          k;
    ops = '{7'h03, 7'h0F, 7'h13, 7'h17, 7'h1B, 7'h23, 7'h33,
            7'h37, 7'h3B, 7'h63, 7'h67, 7'h6F, 7'h73};
    r = $urandom;
    k = $urandom_range(0, 15);
    if (k < 13) r[6:0] = ops[k];
    else if (k == 15) r[1:0] = 2'($urandom_range(0, 2));
    return r;
  endfunction

  task automatic drive(input bit iv, input exp_t e, input bit ordy, input bit fl);
    in_valid  = iv;
    in_instr  = e.instr;
    in_pc     = e.pc;
    out_ready = ordy;
    flush     = fl;
    cur       = e;
    #1;
  endtask

  // Evaluates the handshake seen before the next rising edge, then advances a cycle.
  task automatic tick();
    bit   acc;
    bit   fire;
    exp_t h;
    check("ovld32", {63'b0, vld32}, {63'b0, q.size() != 0});
    check("ovld64", {63'b0, vld64}, {63'b0, q.size() != 0});
    check("irdy32", {63'b0, rdy32}, {63'b0, q.size() < 2});
    check("irdy64", {63'b0, rdy64}, {63'b0, q.size() < 2});
    acc  = in_valid && rdy32;
    fire = vld32 && out_ready;
    if (fire && q.size() != 0) begin
      h = q.pop_front();
      check("imm32",   {32'b0, imm32},   h.imm32);
      check("ty32",    {61'b0, ty32},    {61'b0, h.ty32});
      check("ill32",   {63'b0, ill32},   {63'b0, h.ill32});
      check("pc32",    {32'b0, pc32},    {32'b0, h.pc[31:0]});
      check("instr32", {32'b0, instr32}, {32'b0, h.instr});
      check("imm64",   imm64,            h.imm64);
      check("ty64",    {61'b0, ty64},    {61'b0, h.ty64});
      check("ill64",   {63'b0, ill64},   {63'b0, h.ill64});
      check("pc64",    pc64,             h.pc);
      check("instr64", {32'b0, instr64}, {32'b0, h.instr});
    end
    if (flush) q.delete();
    else if (acc) q.push_back(cur);
    @(negedge clk);
  endtask

  initial begin
    exp_t idle, a, b, c, d, e;
    int   n;
    rst_n = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_instr = '0; in_pc = '0;
    #1 rst_n = 1'b0;
    #1;
    check("rst_vld32",  {63'b0, vld32}, 64'd0);
    check("rst_rdy32",  {63'b0, rdy32}, 64'd1);
    check("rst_imm32",  {32'b0, imm32}, 64'd0);
    check("rst_ty32",   {61'b0, ty32},  64'd0);
    check("rst_ill32",  {63'b0, ill32}, 64'd0);
    check("rst_pc32",   {32'b0, pc32},  64'd0);
    check("rst_vld64",  {63'b0, vld64}, 64'd0);
    check("rst_rdy64",  {63'b0, rdy64}, 64'd1);
    check("rst_imm64",  imm64,          64'd0);
    check("rst_instr64", {32'b0, instr64}, 64'd0);
    #1 rst_n = 1'b1;
    @(negedge clk);

    idle = mk_model(32'h0000_0013, 64'h0);
    dir.push_back(mk_lit(32'hFFF00093, 64'hDEAD_BEEF_0000_1000, 32'hFFFFFFFF, 3'd1, 1'b0, 64'hFFFFFFFFFFFFFFFF, 3'd1, 1'b0));
    dir.push_back(mk_lit(32'hFE000EE3, 64'h0000_0000_0000_1004, 32'hFFFFFFFC, 3'd3, 1'b0, 64'hFFFFFFFFFFFFFFFC, 3'd3, 1'b0));
    dir.push_back(mk_lit(32'h300FD073, 64'h0000_0001_0000_1008, 32'h0000001F, 3'd6, 1'b0, 64'h000000000000001F, 3'd6, 1'b0));
    dir.push_back(mk_lit(32'h800002B7, 64'h0000_0000_8000_000C, 32'h80000000, 3'd4, 1'b0, 64'hFFFFFFFF80000000, 3'd4, 1'b0));
    dir.push_back(mk_lit(32'h0010009B, 64'h0000_0000_0000_1010, 32'h00000000, 3'd0, 1'b1, 64'h0000000000000001, 3'd1, 1'b0));
    dir.push_back(mk_lit(32'h0000003B, 64'h0000_0000_0000_1014, 32'h00000000, 3'd0, 1'b1, 64'h0000000000000000, 3'd0, 1'b0));
    dir.push_back(mk_lit(32'h00000033, 64'h0000_0000_0000_1018, 32'h00000000, 3'd0, 1'b0, 64'h0000000000000000, 3'd0, 1'b0));
    dir.push_back(mk_lit(32'h800000EF, 64'h0000_0000_0000_101C, 32'hFFF00000, 3'd5, 1'b0, 64'hFFFFFFFFFFF00000, 3'd5, 1'b0));
    dir.push_back(mk_lit(32'hFE112E23, 64'h0000_0000_0000_1020, 32'hFFFFFFFC, 3'd2, 1'b0, 64'hFFFFFFFFFFFFFFFC, 3'd2, 1'b0));
    dir.push_back(mk_lit(32'h12345017, 64'h0000_0000_0000_1024, 32'h12345000, 3'd4, 1'b0, 64'h0000000012345000, 3'd4, 1'b0));
    dir.push_back(mk_lit(32'h00001073, 64'h0000_0000_0000_1028, 32'h00000000, 3'd1, 1'b0, 64'h0000000000000000, 3'd1, 1'b0));
    dir.push_back(mk_lit(32'h0000000F, 64'h0000_0000_0000_102C, 32'h00000000, 3'd1, 1'b0, 64'h0000000000000000, 3'd1, 1'b0));
    dir.push_back(mk_lit(32'hFFF00067, 64'h0000_0000_0000_1030, 32'hFFFFFFFF, 3'd1, 1'b0, 64'hFFFFFFFFFFFFFFFF, 3'd1, 1'b0));
    dir.push_back(mk_lit(32'h00000001, 64'h0000_0000_0000_1034, 32'h00000000, 3'd0, 1'b1, 64'h0000000000000000, 3'd0, 1'b1));

    foreach (dir[k]) begin
      drive(1'b1, dir[k], 1'b1, 1'b0);
      tick();
    end
    drive(1'b0, idle, 1'b1, 1'b0); tick();
    drive(1'b0, idle, 1'b1, 1'b0); tick();

    // Skid fill and release
    a = mk_model(32'hFFF00093, 64'h2000);
    b = mk_model(32'h800002B7, 64'h2004);
    drive(1'b1, a, 1'b0, 1'b0); tick();
    drive(1'b1, b, 1'b0, 1'b0);
    check("rdy_at_b", {63'b0, rdy32}, 64'd1);
    tick();
    repeat (3) begin
      drive(1'b0, idle, 1'b0, 1'b0);
      check("stall_rdy",   {63'b0, rdy32},   64'd0);
      check("stall_instr", {32'b0, instr32}, {32'b0, a.instr});
      tick();
    end
    drive(1'b0, idle, 1'b1, 1'b0); tick();
    drive(1'b0, idle, 1'b1, 1'b0);
    check("b_out",    {32'b0, instr32}, {32'b0, b.instr});
    check("rdy_back", {63'b0, rdy32},   64'd1);
    tick();
    drive(1'b0, idle, 1'b1, 1'b0); tick();

    // Flush with the skid full, then with a same-cycle accept
    c = mk_model(32'h0000003B, 64'h3000);
    d = mk_model(32'hFE000EE3, 64'h3004);
    e = mk_model(32'h300FD073, 64'h3008);
    drive(1'b1, a, 1'b0, 1'b0); tick();
    drive(1'b1, b, 1'b0, 1'b0); tick();
    drive(1'b1, c, 1'b0, 1'b1); tick();
    drive(1'b0, idle, 1'b0, 1'b0);
    check("fl_vld", {63'b0, vld32}, 64'd0);
    check("fl_rdy", {63'b0, rdy32}, 64'd1);
    tick();
    drive(1'b1, a, 1'b0, 1'b0); tick();
    drive(1'b1, d, 1'b0, 1'b1); tick();
    drive(1'b1, e, 1'b1, 1'b0); tick();
    drive(1'b0, idle, 1'b1, 1'b0); tick();
    drive(1'b0, idle, 1'b1, 1'b0); tick();

    // Asynchronous reset while stalled
    drive(1'b1, a, 1'b0, 1'b0); tick();
    drive(1'b0, idle, 1'b0, 1'b0);
    check("pre_rst_vld", {63'b0, vld32}, 64'd1);
    #1 rst_n = 1'b0;
    #1;
    check("arst_vld32", {63'b0, vld32}, 64'd0);
    check("arst_vld64", {63'b0, vld64}, 64'd0);
    check("arst_rdy32", {63'b0, rdy32}, 64'd1);
    q.delete();
    #1 rst_n = 1'b1;
    @(negedge clk);
    drive(1'b1, mk_lit(32'h00000000, 64'h4000, 32'h0, 3'd0, 1'b1, 64'h0, 3'd0, 1'b1), 1'b1, 1'b0);
    tick();
    drive(1'b0, idle, 1'b1, 1'b0); tick();
    drive(1'b0, idle, 1'b1, 1'b0); tick();

    // Random traffic with back-pressure and occasional flush
    for (int k = 0; k < 400; k++) begin
      drive($urandom_range(0, 3) != 0,
            mk_model(rand_instr(), {$urandom, $urandom}),
            $urandom_range(0, 3) != 0,
            $urandom_range(0, 29) == 0);
      tick();
    end
    n = 0;
    while (q.size() != 0 && n < 20) begin
      drive(1'b0, idle, 1'b1, 1'b0);
      tick();
      n++;
    end
    check("drained", 64'(q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/imm_decode_stage.md
Name: imm_decode_stage

Overview:
- Registered immediate-generation pipeline stage between fetch and decode in the scalar core.
- Decodes the immediate for every RV32I/RV64I base opcode, including JALR, LUI/AUIPC, SYSTEM/CSR zimm and OP-IMM-32.
- Outputs immediate type and illegal flag, and carries PC and instruction alongside.
- Generalises the combinational immediate generator with XLEN parametrisation, a valid/ready handshake with optional skid buffer, and synchronous flush.

Parameters:
XLEN, 32, datapath width; legal values 32 or 64
SKID, 1, 1 = two-entry skid buffer (in_ready registered-state only); 0 = single register, in_ready = !out_valid || out_ready

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
flush  input  1  synchronous pipeline kill
in_valid  input  1  upstream instruction valid
in_ready  output  1  stage can accept
in_instr  input  32  raw instruction word
in_pc  input  XLEN  instruction address
out_valid  output  1  result valid
out_ready  input  1  downstream accepts
out_imm  output  XLEN  sign/zero-extended immediate
out_imm_type  output  3  0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J, 6 Z; 7 unused
out_illegal  output  1  opcode not supported at this XLEN
out_pc  output  XLEN  registered in_pc
out_instr  output  32  registered in_instr

Behaviour:
- Reset (rst_n low, async): out_valid=0, skid entry invalid, all data outputs 0, out_imm_type=0, out_illegal=0. in_ready=1 whenever the skid entry is empty, including during reset.
- Accept: in_valid && in_ready at a rising edge. The decoded result appears on the outputs the next cycle (latency 1).
- Output hold: while out_valid && !out_ready, all out_* remain stable.
- SKID=1:
  - An accept while the output is stalled writes the skid entry; in_ready deasserts the following cycle.
  - When out_ready is high and the skid entry is valid, the skid entry moves to the output; in_ready reasserts the next cycle.
  - Order is strictly preserved; no drop, no duplicate.
  - A simultaneous accept and output drain with the skid empty loads the output register directly.
- SKID=0: in_ready = !out_valid || out_ready (combinational), single entry.
- Flush:
  - Clears out_valid and the skid entry the next cycle; in_ready=1.
  - An input accepted in the flush cycle is discarded.
  - Flush has priority over all other events.
  - Data registers need not clear.
- Decode rules (instr[1:0] must be 2'b11, else illegal):
  - LOAD 0000011, OP-IMM 0010011, JALR 1100111, MISC-MEM 0001111: I type. imm = sext(instr[31:20]).
  - STORE 0100011: S type. imm = sext({instr[31:25], instr[11:7]}).
  - BRANCH 1100011: B type. imm = sext({instr[31], instr[7], instr[30:25], instr[11:8], 0}).
  - JAL 1101111: J type. imm = sext({instr[31], instr[19:12], instr[20], instr[30:21], 0}).
  - LUI 0110111, AUIPC 0010111: U type. imm = sext({instr[31:12], 12'b0}); for XLEN=64, bits 63:32 = instr[31].
  - SYSTEM 1110011:
    - funct3[2]=1: Z type. imm = zext(instr[19:15]).
    - Otherwise: I type.
  - OP 0110011: NONE, imm 0.
  - OP-IMM-32 0011011: I type when XLEN=64, illegal when XLEN=32.
  - OP-32 0111011: NONE when XLEN=64, illegal when XLEN=32.
  - Any other opcode: illegal.
- Illegal instructions: out_illegal=1, out_imm=0, out_imm_type=NONE. The instruction is still passed through with valid and handshake behaviour unchanged.
- Sign extension is always from instr[31] to XLEN; no truncation occurs at either XLEN.

Decomposition:
- Shared package/include riscv_imm_pkg:
  - 7-bit opcode constants.
  - 3-bit imm-type codes.
  - XLEN legality check.
- Sub-module imm_decode_core: purely combinational instruction -> {imm, imm_type, illegal}, parametrised by XLEN.
- The top level holds only handshake, skid and flush logic.

Test Plan:
- XLEN=32, in_instr=0xFFF00093 (addi x1,x0,-1) -> next cycle out_imm=0xFFFFFFFF, type=1, illegal=0, out_pc echoes in_pc.
- in_instr=0xFE000EE3 (beq x0,x0,-4) -> out_imm=0xFFFFFFFC, type=3. in_instr=0x300FD073 (csrrwi x0,0x300,31) -> out_imm=0x0000001F, type=6.
- XLEN=64, in_instr=0x800002B7 (lui x5,0x80000) -> out_imm=0xFFFFFFFF80000000, type=4. Same XLEN, OP-IMM-32 0x0010009B -> type=1, imm=1. At XLEN=32 the same word gives illegal=1, imm=0.
- SKID=1, send A and B back-to-back with out_ready=0 for 3 cycles -> in_ready low from the cycle after B is accepted. On release, A then B emerge on consecutive cycles; in_ready returns high one cycle after B moves to the output.
- Skid full, assert flush with in_valid=1 -> next cycle out_valid=0, in_ready=1, and neither the flushed entries nor the same-cycle input ever appear.
- Assert rst_n low asynchronously mid-stall -> out_valid drops immediately without a clock edge. After release, 0x00000000 is accepted -> illegal=1, imm=0, type=0.
